// File: rtl/mac_arb_pkg.sv
// Shared types and default widths for the multiply-add port arbiter.
package mac_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int NREQ_DEF = 4;
   localparam int WA_DEF   = 8;
   localparam int WB_DEF   = 8;
   localparam int WS_DEF   = 16;
   localparam int WP_DEF   = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward
// from the index after i_last_grant, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_last_grant,
   output logic [NREQ-1:0] o_grant,
   output logic [IW-1:0]   o_grant_idx,
   output logic            o_any
);

   logic [IW-1:0] w_idx;

   always_comb begin
      // NOTE: blocking assignments here so each loop pass sees o_any as left by the previous pass.
      o_grant     = '0;
      o_grant_idx = '0;
      o_any       = 1'b0;
      w_idx       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = IW'((int'(i_last_grant) + k) % NREQ);
         if (!o_any && i_req[w_idx]) begin
            o_any          = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_grant_idx    = w_idx;
         end
      end
   end

endmodule

// File: rtl/mac_port_arbiter.sv
// Time-shares one combinational multiply-add unit among NREQ requesters:
// accept in IDLE, drive the unit for one ISSUE cycle, hold the result in HOLD.
module mac_port_arbiter
   import mac_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int WA   = WA_DEF,
   parameter int WB   = WB_DEF,
   parameter int WS   = WS_DEF,
   parameter int WP   = WP_DEF
) (
   input  logic             clock,
   input  logic             sclr_n,
   input  logic [NREQ-1:0]  req_valid,
   output logic [NREQ-1:0]  req_ready,
   input  logic [NREQ*WA-1:0] req_a,
   input  logic [NREQ*WB-1:0] req_b,
   input  logic [NREQ*WS-1:0] req_s,
   output logic [NREQ-1:0]  rsp_valid,
   input  logic [NREQ-1:0]  rsp_ready,
   output logic [WP-1:0]    rsp_data,
   output logic [WA-1:0]    mu_dataa,
   output logic [WB-1:0]    mu_datab,
   output logic [WS-1:0]    mu_sum,
   output logic             mu_aclr,
   input  logic [WP-1:0]    mu_result
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          r_state, w_state_nxt;
   logic [IW-1:0]   r_cur, r_last_grant, w_gidx;
   logic [NREQ-1:0] w_grant, w_cur_onehot;
   logic            w_any;
   logic [WA-1:0]   r_a;
   logic [WB-1:0]   r_b;
   logic [WS-1:0]   r_s;
   logic [NREQ-1:0] r_rsp_valid;
   logic [WP-1:0]   r_rsp_data;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .i_req        (req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_grant_idx  (w_gidx),
      .o_any        (w_any)
   );

   always_ff @(posedge clock) begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      if (!sclr_n) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      w_state_nxt = r_state;
      req_ready   = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready = sclr_n ? w_grant : '0;
            if (w_any) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: w_state_nxt = ST_HOLD;
         ST_HOLD:  if (rsp_ready[r_cur]) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_cur_onehot = NREQ'(1) << r_cur;

   always_ff @(posedge clock) begin
      if (!sclr_n) begin
         r_cur        <= '0;
         r_last_grant <= IW'(NREQ - 1);
         r_a          <= '0;
         r_b          <= '0;
         r_s          <= '0;
         r_rsp_valid  <= '0;
         r_rsp_data   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_any) begin
               r_cur <= w_gidx;
               r_a   <= req_a[w_gidx*WA +: WA];
               r_b   <= req_b[w_gidx*WB +: WB];
               r_s   <= req_s[w_gidx*WS +: WS];
            end
            ST_ISSUE: begin
               r_rsp_data  <= mu_result;
               r_rsp_valid <= w_cur_onehot;
            end
            ST_HOLD: if (rsp_ready[r_cur]) begin
               r_rsp_valid  <= '0;
               r_last_grant <= r_cur;
            end
            default: ;
         endcase
      end
   end

   // Operand registers feed the unit continuously; only the clear tracks ISSUE.
   assign mu_dataa  = r_a;
   assign mu_datab  = r_b;
   assign mu_sum    = r_s;
   assign mu_aclr   = (r_state != ST_ISSUE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_mac_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-age model
// of the arbiter and an (a+b+s) mod 2^WP model of the shared unit.
module tb_mac_port_arbiter;
   import mac_arb_pkg::*;

   localparam int NREQ = NREQ_DEF;
   localparam int WA   = WA_DEF;
   localparam int WB   = WB_DEF;
   localparam int WS   = WS_DEF;
   localparam int WP   = WP_DEF;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                 sclr_n;
   logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NREQ*WA-1:0]   req_a;
   logic [NREQ*WB-1:0]   req_b;
   logic [NREQ*WS-1:0]   req_s;
   logic [WP-1:0]        rsp_data, mu_result;
   logic [WA-1:0]        mu_dataa;
   logic [WB-1:0]        mu_datab;
   logic [WS-1:0]        mu_sum;
   logic                 mu_aclr;

   mac_port_arbiter #(.NREQ(NREQ), .WA(WA), .WB(WB), .WS(WS), .WP(WP)) dut (
      .clock(clock), .sclr_n(sclr_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_s(req_s),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .mu_dataa(mu_dataa), .mu_datab(mu_datab), .mu_sum(mu_sum),
      .mu_aclr(mu_aclr), .mu_result(mu_result)
   );

   // The shared arithmetic unit the arbiter drives.
   assign mu_result = WP'(mu_dataa) + WP'(mu_datab) + WP'(mu_sum);

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: transaction age (-1 idle, 1 issuing, >=2 awaiting response).
   int              m_age   = -1;
   int              m_owner = 0;
   int              m_ptr   = NREQ - 1;
   logic [WA-1:0]   m_a     = '0;
   logic [WB-1:0]   m_b     = '0;
   logic [WS-1:0]   m_s     = '0;
   logic [WP-1:0]   m_rsp   = '0;
   bit              m_chk   = 1'b0;
   int              m_g;
   logic [NREQ-1:0] e_ready, e_valid;

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 1; k <= NREQ; k++) begin
         int i;
         i = (ptr + k) % NREQ;
         if (v[i[1:0]]) return i;
      end
      return -1;
   endfunction

   always @(negedge clock) begin
      m_g     = rr_pick(req_valid, m_ptr);
      e_ready = (sclr_n && m_age < 0 && m_g >= 0) ? (NREQ'(1) << m_g) : '0;
      e_valid = (m_age >= 2) ? (NREQ'(1) << m_owner) : '0;
      if (m_chk) begin
         check("req_ready", 64'(req_ready), 64'(e_ready));
         check("mu_aclr",   64'(mu_aclr),   64'(m_age != 1));
         check("rsp_valid", 64'(rsp_valid), 64'(e_valid));
         check("rsp_data",  64'(rsp_data),  64'(m_rsp));
         check("mu_ops",    64'({mu_dataa, mu_datab, mu_sum}), 64'({m_a, m_b, m_s}));
      end
      if (!sclr_n) begin
         m_age = -1; m_ptr = NREQ - 1; m_rsp = '0;
         m_a = '0; m_b = '0; m_s = '0;
         m_chk = 1'b1;
      end else if (m_age < 0) begin
         if (m_g >= 0) begin
            m_owner = m_g;
            m_a = req_a[m_g*WA +: WA];
            m_b = req_b[m_g*WB +: WB];
            m_s = req_s[m_g*WS +: WS];
            m_age = 1;
         end
      end else if (m_age == 1) begin
         m_rsp = WP'((int'(m_a) + int'(m_b) + int'(m_s)) % (1 << WP));
         m_age = 2;
      end else if (rsp_ready[m_owner[1:0]]) begin
         m_ptr = m_owner;
         m_age = -1;
      end else begin
         m_age++;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input int a, input int b, input int s);
      req_a[i*WA +: WA] = WA'(a);
      req_b[i*WB +: WB] = WB'(b);
      req_s[i*WS +: WS] = WS'(s);
   endtask

   function automatic int oh2idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   int g_idx[$];
   int g_cyc[$];
   int exp_order[6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      sclr_n = 1'b0; req_valid = '0; rsp_ready = '1;
      req_a = '0; req_b = '0; req_s = '0;
      repeat (2) step();
      sclr_n = 1'b1;

      // All four requesting continuously with responses always accepted.
      for (int i = 0; i < NREQ; i++)
         set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
      req_valid = '1;
      for (int c = 0; c < 18; c++) begin
         @(negedge clock);
         if (req_ready != '0) begin
            g_idx.push_back(oh2idx(req_ready));
            g_cyc.push_back(c);
         end
         step();
      end
      req_valid = '0;
      check("t2_ngrants", 64'(g_idx.size()), 64'd6);
      for (int i = 0; i < 6 && i < g_idx.size(); i++) begin
         check($sformatf("t2_order%0d", i), 64'(g_idx[i]), 64'(exp_order[i]));
         if (i > 0) check($sformatf("t2_space%0d", i), 64'(g_cyc[i] - g_cyc[i-1]), 64'd3);
      end

      // Single request from requester 0.
      set_req(0, 3, 5, 10);
      req_valid = 4'b0001;
      @(negedge clock);
      check("t1_ready",   64'(req_ready), 64'h1);
      check("t1_aclr_T",  64'(mu_aclr),   64'h1);
      step(); req_valid = '0;
      @(negedge clock);
      check("t1_aclr_T1", 64'(mu_aclr),   64'h0);
      step();
      @(negedge clock);
      check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
      check("t1_rsp_data",  64'(rsp_data),  64'd18);
      check("t1_aclr_T2",   64'(mu_aclr),   64'h1);
      step();

      // Response backpressure on requester 1 with a stray ready on index 2.
      set_req(1, 100, 20, 1000);
      req_valid = 4'b0010; rsp_ready = 4'b0100;
      @(negedge clock);
      check("t3_ready", 64'(req_ready), 64'h2);
      step(); req_valid = 4'b0001;
      step();
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         check($sformatf("t3_valid%0d", c), 64'(rsp_valid), 64'h2);
         check($sformatf("t3_data%0d", c),  64'(rsp_data),  64'd1120);
         check($sformatf("t3_noready%0d", c), 64'(req_ready), 64'h0);
         step();
      end
      rsp_ready = 4'b0010;
      step();
      @(negedge clock);
      check("t3_next_grant", 64'(req_ready), 64'h1);
      step(); req_valid = '0; rsp_ready = '1;
      repeat (3) step();

      // Reset during ISSUE; pointer must return to NREQ-1.
      set_req(2, 7, 7, 7);
      req_valid = 4'b0100;
      step(); req_valid = '0;
      repeat (3) step();
      req_valid = 4'b0010;
      step(); req_valid = '0; sclr_n = 1'b0;
      step(); sclr_n = 1'b1; req_valid = 4'b1100;
      @(negedge clock);
      check("t4_rsp_valid", 64'(rsp_valid), 64'h0);
      check("t4_rsp_data",  64'(rsp_data),  64'h0);
      check("t4_aclr",      64'(mu_aclr),   64'h1);
      check("t4_req2_first", 64'(req_ready), 64'h4);
      step(); req_valid = '0;
      repeat (3) step();

      // Overflow wraps modulo 2^WP.
      set_req(0, 255, 255, 65535);
      req_valid = 4'b0001;
      step(); req_valid = '0;
      step();
      @(negedge clock);
      check("t5_rsp_valid", 64'(rsp_valid), 64'h1);
      check("t5_rsp_data",  64'(rsp_data),  64'd509);
      repeat (2) step();

      // Requester 3 raises and withdraws its request during HOLD.
      set_req(0, 1, 2, 3);
      req_valid = 4'b0001; rsp_ready = '0;
      step(); req_valid = '0;
      step(); req_valid = 4'b1000;
      step(); req_valid = '0; rsp_ready = '1;
      step();
      @(negedge clock);
      check("t6_ready0", 64'(req_ready), 64'h0);
      check("t6_aclr",   64'(mu_aclr),   64'h1);
      check("t6_rsp",    64'(rsp_valid), 64'h0);
      step();
      @(negedge clock);
      check("t6_ready1", 64'(req_ready), 64'h0);

      // Randomized traffic, checked every cycle by the model.
      for (int c = 0; c < 400; c++) begin
         step();
         for (int i = 0; i < NREQ; i++)
            set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
         req_valid = NREQ'($urandom);
         rsp_ready = NREQ'($urandom);
         sclr_n    = ($urandom_range(0, 63) != 0);
      end
      step();
      sclr_n = 1'b1; req_valid = '0; rsp_ready = '1;
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
